// File: rtl/snn_enc_pkg.sv
// Shared definitions for the Poisson spike encoder: LFSR constants, config select
// encodings and the LFSR step function.
package snn_enc_pkg;

    localparam int unsigned        LFSR_W        = 16;
    localparam logic [LFSR_W-1:0]  LFSR_TAPS     = 16'hB400;
    localparam logic [LFSR_W-1:0]  LFSR_ZERO_SUB = 16'hACE1;

    typedef enum logic [1:0] {
        CFG_RATE = 2'b00,
        CFG_SEED = 2'b01,
        CFG_REFR = 2'b10,
        CFG_NONE = 2'b11
    } cfg_sel_e;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    // An all-zero LFSR would never leave zero, so substitute a known good seed.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_ZERO_SUB : s;
    endfunction

endpackage

// File: rtl/spike_channel.sv
// One Poisson-rate channel: LFSR, rate compare, refractory hold-off and the
// registered spike flop.
module spike_channel
    import snn_enc_pkg::*;
#(
    parameter int unsigned       RATE_W    = 8,
    parameter int unsigned       REFRACT_W = 4,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_ZERO_SUB
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic              rate_wr_i,
    input  logic              seed_wr_i,
    input  logic              refr_wr_i,
    input  logic [LFSR_W-1:0] cfg_data_i,
    output logic              spike_o,
    output logic              busy_next_o
);

    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [RATE_W-1:0]    rate_q, rate_d;
    logic [REFRACT_W-1:0] refr_period_q, refr_period_d;
    logic [REFRACT_W-1:0] refr_cnt_q, refr_cnt_d;
    logic                 spike_q, spike_d;
    logic                 fire;

    always_comb begin
        fire = run_i && (refr_cnt_q == '0) && (lfsr_q[RATE_W-1:0] < rate_q);
        spike_d = fire;

        lfsr_d = lfsr_q;
        if (seed_wr_i) begin
            lfsr_d = seed_fix(cfg_data_i);
        end else if (run_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end

        rate_d        = rate_wr_i ? cfg_data_i[RATE_W-1:0] : rate_q;
        refr_period_d = refr_wr_i ? cfg_data_i[REFRACT_W-1:0] : refr_period_q;

        // A spike loads the period held before any same-cycle write.
        refr_cnt_d = refr_cnt_q;
        if (fire) begin
            refr_cnt_d = refr_period_q;
        end else if (run_i && (refr_cnt_q != '0)) begin
            refr_cnt_d = refr_cnt_q - REFRACT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q        <= SEED;
            rate_q        <= '0;
            refr_period_q <= '0;
            refr_cnt_q    <= '0;
            spike_q       <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            rate_q        <= rate_d;
            refr_period_q <= refr_period_d;
            refr_cnt_q    <= refr_cnt_d;
            spike_q       <= spike_d;
        end
    end

    assign spike_o     = spike_q;
    assign busy_next_o = (refr_cnt_d != '0);

endmodule

// File: rtl/poisson_spike_encoder.sv
// Poisson-rate spike source: config decode, per-channel instances and busy flag.
// Define SPIKE_COUNT_EN to add per-channel saturating spike counters.
module poisson_spike_encoder
    import snn_enc_pkg::*;
#(
    parameter int unsigned N_CH      = 5,
    parameter int unsigned RATE_W    = 8,
    parameter int unsigned REFRACT_W = 4,
    parameter logic [15:0] SEED_BASE = 16'hACE1,
    localparam int unsigned ADDR_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [15:0]       cfg_data,
`ifdef SPIKE_COUNT_EN
    input  logic              cnt_clr,
    input  logic [ADDR_W-1:0] cnt_addr,
    output logic [31:0]       cnt_q,
`endif
    output logic [N_CH-1:0]   spikes_out,
    output logic              busy
);

    logic [N_CH-1:0] rate_wr, seed_wr, refr_wr, busy_next;
    logic            busy_q;

    // Out-of-range addresses and CFG_NONE match no channel and are dropped.
    always_comb begin
        rate_wr = '0;
        seed_wr = '0;
        refr_wr = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (cfg_wr && (32'(cfg_addr) == i)) begin
                rate_wr[i] = (cfg_sel == CFG_RATE);
                seed_wr[i] = (cfg_sel == CFG_SEED);
                refr_wr[i] = (cfg_sel == CFG_REFR);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [LFSR_W-1:0] ChSeed = seed_fix(SEED_BASE ^ 16'(i * 16'h1F1F));

        spike_channel #(
            .RATE_W    (RATE_W),
            .REFRACT_W (REFRACT_W),
            .SEED      (ChSeed)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (reset),
            .run_i       (run),
            .rate_wr_i   (rate_wr[i]),
            .seed_wr_i   (seed_wr[i]),
            .refr_wr_i   (refr_wr[i]),
            .cfg_data_i  (cfg_data),
            .spike_o     (spikes_out[i]),
            .busy_next_o (busy_next[i])
        );
    end

    // Built from next-state counters so busy lines up with the registered counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |busy_next;
        end
    end

    assign busy = busy_q;

`ifdef SPIKE_COUNT_EN
    logic [31:0] spk_cnt_q [N_CH];
    logic [31:0] spk_cnt_d [N_CH];

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            spk_cnt_d[i] = spk_cnt_q[i];
            if (cnt_clr) begin
                spk_cnt_d[i] = '0;
            end else if (spikes_out[i] && (spk_cnt_q[i] != '1)) begin
                spk_cnt_d[i] = spk_cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                spk_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                spk_cnt_q[i] <= spk_cnt_d[i];
            end
        end
    end

    always_comb begin
        cnt_q = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(cnt_addr) == i) begin
                cnt_q = spk_cnt_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Directed self-checking bench for poisson_spike_encoder (default build).
module tb_poisson_spike_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_sel = 2'b00;
    logic [2:0]  cfg_addr = 3'd0;
    logic [15:0] cfg_data = 16'h0000;
    logic [4:0]  spikes_out;
    logic        busy;
`ifdef SPIKE_COUNT_EN
    logic        cnt_clr = 1'b0;
    logic [2:0]  cnt_addr = 3'd0;
    logic [31:0] cnt_q;
`endif

    poisson_spike_encoder u_dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
`ifdef SPIKE_COUNT_EN
        .cnt_clr    (cnt_clr),
        .cnt_addr   (cnt_addr),
        .cnt_q      (cnt_q),
`endif
        .spikes_out (spikes_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] ref_trace [100];
    logic       trace0 [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [2:0] addr, input logic [15:0] data);
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        cfg_wr   = 1'b1;
        tick();
        cfg_wr   = 1'b0;
    endtask

    task automatic apply_reset();
        run = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic write_trace_rates();
        cfg(2'b00, 3'd0, 16'd128);
        cfg(2'b00, 3'd1, 16'd255);
        cfg(2'b00, 3'd2, 16'd60);
        cfg(2'b00, 3'd3, 16'd200);
        cfg(2'b00, 3'd4, 16'd30);
        cfg(2'b10, 3'd4, 16'd2);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    initial begin
        int         bad_spk, bad_busy, cnt0, cnt1, mism, mism2;
        int         last, h, nspk, spacing_bad, busy_bad, frozen_bad;
        logic [15:0] m;
        logic        exp_spk;
        logic [3:0]  hand_exp;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("reset_spikes", 32'(spikes_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Rate zero everywhere; ignored writes must not arm any channel
        cfg(2'b11, 3'd0, 16'h00FF);
        cfg(2'b00, 3'd5, 16'h00FF);
        cfg(2'b00, 3'd7, 16'h00FF);
        run = 1'b1;
        bad_spk = 0;
        bad_busy = 0;
        repeat (10000) begin
            tick();
            if (spikes_out != 5'd0) bad_spk++;
            if (busy) bad_busy++;
        end
        run = 1'b0;
        check("rate0_spike_cycles", 32'(bad_spk), 32'd0);
        check("rate0_busy_cycles", 32'(bad_busy), 32'd0);

        // Full LFSR period: ch0 rate 128, ch1 rate 255
        apply_reset();
        write_trace_rates();
        run = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 65535; k++) begin
            tick();
            if (k < 100) ref_trace[k] = spikes_out;
            cnt0 += int'(spikes_out[0]);
            cnt1 += int'(spikes_out[1]);
        end
        check("rate128_ch0_count", 32'(cnt0), 32'd32767);
        check("rate255_ch1_count", 32'(cnt1), 32'd65279);

        // Mid-run reset between edges
        tick();
        tick();
        #3 reset = 1'b0;
        #1;
        check("midreset_spikes", 32'(spikes_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        run = 1'b0;
        tick();
        reset = 1'b1;
        write_trace_rates();
        run = 1'b1;
        mism = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (spikes_out !== ref_trace[k]) mism++;
        end
        run = 1'b0;
        check("midreset_trace_mismatches", 32'(mism), 32'd0);

        // Refractory spacing on ch2
        apply_reset();
        cfg(2'b00, 3'd2, 16'd255);
        cfg(2'b10, 3'd2, 16'd3);
        run = 1'b1;
        last = -100;
        h = 0;
        nspk = 0;
        spacing_bad = 0;
        busy_bad = 0;
        for (int s = 0; s < 400; s++) begin
            tick();
            if (spikes_out[2]) begin
                nspk++;
                if (s - last < 4) spacing_bad++;
                last = s;
                h = 3;
            end else if (h > 0) begin
                h--;
            end
            if (busy !== (h != 0)) busy_bad++;
        end
        run = 1'b0;
        check("refr_spacing_violations", 32'(spacing_bad), 32'd0);
        check("refr_busy_mismatches", 32'(busy_bad), 32'd0);
        check("refr_enough_spikes", 32'(nspk >= 90), 32'd1);

        // Zero seed on ch3 behaves as 0xACE1; freeze mid-stream
        apply_reset();
        cfg(2'b00, 3'd3, 16'd128);
        cfg(2'b01, 3'd3, 16'h0000);
        hand_exp = 4'b0110;
        m = 16'hACE1;
        mism = 0;
        frozen_bad = 0;
        run = 1'b1;
        for (int s = 0; s < 200; s++) begin
            if (s == 100) begin
                run = 1'b0;
                tick();
                check("freeze_next_edge", 32'(spikes_out), 32'd0);
                repeat (4) begin
                    tick();
                    if (spikes_out != 5'd0) frozen_bad++;
                end
                run = 1'b1;
            end
            exp_spk = (m[7:0] < 8'd128);
            m = lfsr_step(m);
            tick();
            if (s < 4) check($sformatf("seed0_first_s%0d", s), 32'(spikes_out[3]), 32'(hand_exp[s]));
            if (s < 64) trace0[s] = spikes_out[3];
            if (spikes_out[3] !== exp_spk) mism++;
        end
        run = 1'b0;
        check("seed0_model_mismatches", 32'(mism), 32'd0);
        check("freeze_hold_spikes", 32'(frozen_bad), 32'd0);

        cfg(2'b01, 3'd3, 16'hACE1);
        run = 1'b1;
        mism2 = 0;
        for (int s = 0; s < 64; s++) begin
            tick();
            if (spikes_out[3] !== trace0[s]) mism2++;
        end
        run = 1'b0;
        check("seedACE1_vs_seed0", 32'(mism2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/poisson_spike_encoder.md
Name: poisson_spike_encoder

Overview:
- Synthesizable Poisson-rate spike source that drives the input_spikes bus of the multi-layer SNN with AER.
- Replaces behavioural exponential-interval stimulus with per-channel 16-bit LFSR + rate compare, giving a Bernoulli-per-cycle approximation of a Poisson train.
- Per-channel rate, seed and refractory hold-off are programmable at run time through a simple write port.

Parameters:
- N_CH, 5, number of spike channels (width of spikes_out)
- RATE_W, 8, rate register width; spike probability per cycle = rate/2^RATE_W
- REFRACT_W, 4, refractory counter width
- SEED_BASE, 16'hACE1, seed for channel 0; channel i resets to SEED_BASE ^ (i*16'h1F1F), forced nonzero

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- run  in  1  1 = LFSRs advance and spikes may fire; 0 = freeze
- cfg_wr  in  1  write strobe, one cycle
- cfg_sel  in  2  00 = rate, 01 = seed, 10 = refractory period
- cfg_addr  in  $clog2(N_CH)  target channel
- cfg_data  in  16  write data; rate uses [RATE_W-1:0], refractory uses [REFRACT_W-1:0]
- spikes_out  out  N_CH  registered spike vector, one-cycle pulses
- busy  out  1  1 while any channel's refractory counter is nonzero

Behaviour:
- Reset (asynchronous, reset=0):
  - spikes_out=0, busy=0.
  - All rates=0, all refractory periods=0, refractory counters=0.
  - LFSR_i = channel seed.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, maximal length 65535. Advances once per cycle only when run=1.
- Spike rule, channel i, registered, 1-cycle latency:
  - spikes_out[i] at cycle t+1 = run(t) & (refr_cnt_i(t)==0) & (LFSR_i(t)[RATE_W-1:0] < rate_i(t)).
  - Compare is unsigned. rate=0 never fires. rate=2^RATE_W-1 fires with probability 255/256.
- Refractory:
  - On a spike, refr_cnt_i loads refr_period_i in the same edge that registers the spike.
  - refr_cnt_i decrements by 1 per cycle while nonzero and run=1. It holds when run=0.
  - Minimum spacing between spikes on one channel is refr_period+1 cycles.
- run=0: spikes_out forced to 0 on the next edge. All state holds.
- Config writes:
  - Take effect at the edge where cfg_wr=1; the new value is used from the next cycle's compare.
  - cfg_addr >= N_CH is ignored. cfg_sel=11 is ignored.
  - A seed write of 16'h0000 loads 16'hACE1, so the LFSR cannot lock up.
  - A seed write overrides that cycle's LFSR advance.
  - A rate or refractory-period write does not disturb refr_cnt.
- Simultaneous events: a write and a spike on the same channel in the same cycle both take effect. The spike loads the old refr_period; the write updates the stored period.
- Reset asserted mid-operation: spikes_out drops to 0 immediately (asynchronously), with no partial pulse. After release, the LFSR sequence restarts from the seeds.
- busy = OR of (refr_cnt_i != 0), registered.

Optional Feature:
- Macro: SPIKE_COUNT_EN.
- With the macro defined:
  - Adds input cnt_clr (1), input cnt_addr ($clog2(N_CH)), output cnt_q (32).
  - Per-channel 32-bit saturating spike counters increment on each spikes_out[i].
  - cnt_q combinationally returns counter[cnt_addr].
  - cnt_clr zeroes all counters. If cnt_clr and a spike coincide, the counter becomes 0.
  - Counters reset to 0.
- Without the macro: no counters and no extra ports; ports and timing are otherwise identical.

Decomposition:
- Shared package snn_enc_pkg:
  - LFSR_W=16, LFSR_TAPS=16'hB400, LFSR_ZERO_SUB=16'hACE1.
  - cfg_sel encodings CFG_RATE/CFG_SEED/CFG_REFR.
  - Function lfsr_next().
- Sub-module: spike_channel, one per channel via generate. It holds the LFSR, rate, refractory period/counter and the spike flop. The top holds config decode and busy.

Test Plan:
- Rate zero:
  - Stimulus: reset, run=1, all rates 0, 10000 cycles.
  - Required response: spikes_out never nonzero; busy=0.
- Rate 128, channel 0:
  - Stimulus: refractory 0, run=1 for exactly 65535 cycles.
  - Required response: exactly 32767 spikes on channel 0.
- Rate 255, channel 1:
  - Stimulus: refractory 0, 65535 cycles.
  - Required response: exactly 65279 spikes.
- Refractory spacing:
  - Stimulus: channel 2 rate 255, refractory 3.
  - Required response: no two channel-2 spikes closer than 4 cycles; busy high during each hold-off.
- Zero seed and freeze:
  - Stimulus: write seed 16'h0000 to channel 3 with rate 128.
  - Required response: spike sequence identical to seed 16'hACE1.
  - Stimulus: drop run mid-stream.
  - Required response: spikes_out=0 next edge; resume continues from the frozen LFSR state.
- Mid-run reset:
  - Stimulus: assert reset=0 between clock edges.
  - Required response: spikes_out=0 immediately. After release, the first 100 cycles match the post-initial-reset trace once rates are rewritten.
